multicycle_control_unit: RTL

- Main sequencer for the multi-cycle RISC-V core. Decodes the instruction opcode and steps a Moore/Mealy FSM through fetch, decode, execute, memory and writeback.
- Drives the shared ALU's source muxes and the 3-bit ALU_Op consumed by ALU_Control, plus the PC, IR, memory and register-file enables.
- Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_control_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RISC-V main control FSM with retire counter
module multicycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode_i,
  input  logic                 mem_ready_i,
  output logic [3:0]           state_o,
  output logic                 pc_write_o,
  output logic                 pc_write_cond_o,
  output logic [1:0]           pc_src_o,
  output logic                 ir_write_o,
  output logic                 i_or_d_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [1:0]           mem_to_reg_o,
  output logic                 reg_write_o,
  output logic [1:0]           alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] retired_count_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_U   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   retire;

  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] pc_src, mem_to_reg, alu_src_a, alu_src_b;
  logic [2:0] alu_op;

  // Next-state, retire and control decode; Mealy terms only in FETCH and the memory waits
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b111;
        if (mem_ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut <= instruction PC + imm, the branch/JAL target
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
        alu_op    = 3'b111;
        case (opcode_i)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LUI:             state_d = S_EXEC_U;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 3'b001;
        state_d   = S_WB_ALU;
      end
      S_EXEC_U: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 3'b100;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready_i) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 3'b011;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    count_d = retire ? count_q + CNT_WIDTH'(1) : count_q;
  end

  // State, sticky illegal flag and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Reset gates every control output combinationally so nothing asserts while reset is high
  always_comb begin
    pc_write_o      = pc_write & ~reset;
    pc_write_cond_o = pc_write_cond & ~reset;
    pc_src_o        = reset ? 2'b00 : pc_src;
    ir_write_o      = ir_write & ~reset;
    i_or_d_o        = i_or_d & ~reset;
    mem_read_o      = mem_read & ~reset;
    mem_write_o     = mem_write & ~reset;
    mem_to_reg_o    = reset ? 2'b00 : mem_to_reg;
    reg_write_o     = reg_write & ~reset;
    alu_src_a_o     = reset ? 2'b00 : alu_src_a;
    alu_src_b_o     = reset ? 2'b00 : alu_src_b;
    alu_op_o        = reset ? 3'b000 : alu_op;
    state_o         = state_q;
    illegal_o       = illegal_q;
    retired_count_o = count_q;
  end

endmodule
